// File: rtl/cpu_stack_pkg.sv
// Shared definitions for the CPU operand stack: task codes used by the
// decoder and by the stack itself.
package cpu_stack_pkg;

  typedef logic [2:0] task_t;

  localparam task_t TASK_STORE = 3'b000;
  localparam task_t TASK_PUSH  = 3'b001;
  localparam task_t TASK_POP2  = 3'b010;
  localparam task_t TASK_SWAP  = 3'b011;
  localparam task_t TASK_POP   = 3'b100;
  localparam task_t TASK_DUP   = 3'b101;
  localparam task_t TASK_ROT   = 3'b110;
  localparam task_t TASK_NOP   = 3'b111;

endpackage

// File: rtl/cpu_stack_strobe.sv
// Operation strobe generator for the operand stack.
// Build option CPU_STACK_LATCH_EDGE_EN: when defined, one operation fires per
// rising edge of Latch (legacy strobe generators hold Latch for several
// cycles); when undefined, every cycle with Latch high fires.
module cpu_stack_strobe (
  input  logic clk_i,
  input  logic reset_i,
  input  logic latch_i,
  output logic fire_o
);

`ifdef CPU_STACK_LATCH_EDGE_EN
  logic lprev_q;

  // Remember last cycle's Latch so a held strobe fires only once.
  always_ff @(posedge clk_i) begin
    if (reset_i) lprev_q <= 1'b0;
    else         lprev_q <= latch_i;
  end

  assign fire_o = latch_i & ~lprev_q;
`else
  // Level mode needs no state; clock and reset are kept on the port list so
  // the instance is identical in both builds.
  logic unused_strobe;
  assign unused_strobe = clk_i ^ reset_i;
  assign fire_o        = latch_i;
`endif

endmodule

// File: rtl/cpu_stack_param.sv
// Parametrised CPU operand stack: WIDTH-bit entries, DEPTH deep, with
// occupancy, full/empty and sticky overflow/underflow flags.
// Build option CPU_STACK_LATCH_EDGE_EN selects edge-triggered Latch
// (see cpu_stack_strobe).
module cpu_stack_param
  import cpu_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [AW-1:0]    Address,
  input  logic [WIDTH-1:0] Input,
  input  logic             Latch,
  input  logic [2:0]       Task,
  input  logic             ClearErr,
  output logic [WIDTH-1:0] Out0,
  output logic [WIDTH-1:0] Out1,
  output logic [WIDTH-1:0] OutA,
  output logic [AW:0]      Count,
  output logic             Full,
  output logic             Empty,
  output logic             Overflow,
  output logic             Underflow
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW + 1)'(1);
  localparam logic [AW:0] TWO_C   = (AW + 1)'(2);

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, unf_q;
  logic             ovf_set, unf_set;
  logic             fire;
  logic             full_w, empty_w;

  cpu_stack_strobe u_strobe (
    .clk_i   (Clk),
    .reset_i (Reset),
    .latch_i (Latch),
    .fire_o  (fire)
  );

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // Next stack contents, occupancy and flag-set requests for the fired task.
  always_comb begin
    s_d     = s_q;
    count_d = count_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (fire) begin
      unique case (task_t'(Task))
        TASK_STORE: begin
          s_d[0] = Input;
          if (empty_w) count_d = ONE_C;
        end
        TASK_PUSH, TASK_DUP: begin
          for (int i = 1; i < DEPTH; i++) s_d[i] = s_q[i-1];
          s_d[0] = (task_t'(Task) == TASK_PUSH) ? Input : s_q[0];
          // A full stack still shifts; the bottom entry is lost.
          if (full_w) ovf_set = 1'b1;
          else        count_d = count_q + ONE_C;
        end
        TASK_POP2: begin
          s_d[0] = Input;
          for (int i = 1; i < DEPTH - 1; i++) s_d[i] = s_q[i+1];
          s_d[DEPTH-1] = '0;
          if (count_q < TWO_C) begin
            unf_set = 1'b1;
            count_d = ONE_C;
          end else begin
            count_d = count_q - ONE_C;
          end
        end
        TASK_SWAP: begin
          if (Address != '0) begin
            s_d[0]       = s_q[Address];
            s_d[Address] = s_q[0];
          end
        end
        TASK_POP: begin
          for (int i = 0; i < DEPTH - 1; i++) s_d[i] = s_q[i+1];
          s_d[DEPTH-1] = '0;
          if (empty_w) unf_set = 1'b1;
          else         count_d = count_q - ONE_C;
        end
        TASK_ROT: begin
          if (Address != '0) begin
            s_d[0] = s_q[Address];
            for (int j = 1; j < DEPTH; j++) begin
              if (j <= int'(Address)) s_d[j] = s_q[j-1];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State register; reset overrides any operation on the same edge and a
  // flag set beats a simultaneous clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) s_q[i] <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      count_q <= count_d;
      ovf_q   <= ovf_set | (ovf_q & ~ClearErr);
      unf_q   <= unf_set | (unf_q & ~ClearErr);
    end
  end

  assign Out0      = s_q[0];
  assign Out1      = s_q[1];
  assign OutA      = s_q[Address];
  assign Count     = count_q;
  assign Full      = full_w;
  assign Empty     = empty_w;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_cpu_stack_param.sv
// Self-checking bench for cpu_stack_param: directed scenarios followed by
// random operations, compared against a queue-based stack model.
module tb_cpu_stack_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  localparam logic [2:0] T_STORE = 3'b000, T_PUSH = 3'b001, T_POP2 = 3'b010,
                         T_SWAP  = 3'b011, T_POP  = 3'b100, T_DUP  = 3'b101,
                         T_ROT   = 3'b110, T_NOP  = 3'b111;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic [AW-1:0]    Address = '0;
  logic [WIDTH-1:0] Input = '0;
  logic             Latch = 1'b0;
  logic [2:0]       Task = T_NOP;
  logic             ClearErr = 1'b0;
  logic [WIDTH-1:0] Out0, Out1, OutA;
  logic [AW:0]      Count;
  logic             Full, Empty, Overflow, Underflow;

  cpu_stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Address(Address), .Input(Input),
    .Latch(Latch), .Task(Task), .ClearErr(ClearErr),
    .Out0(Out0), .Out1(Out1), .OutA(OutA), .Count(Count),
    .Full(Full), .Empty(Empty), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: stack as a queue, front = top, always DEPTH long.
  logic [WIDTH-1:0] q[$];
  int   cnt_m;
  logic ov_m, un_m, lprev_m;

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back('0);
    cnt_m = 0; ov_m = 0; un_m = 0; lprev_m = 0;
  endtask

  task automatic model_step(input logic rst, input logic lat, input logic [2:0] tk,
                            input logic [WIDTH-1:0] din, input int adr, input logic clr);
    logic fire, ovs, uns;
    logic [WIDTH-1:0] tmp;
    if (rst) begin
      model_reset();
      return;
    end
`ifdef CPU_STACK_LATCH_EDGE_EN
    fire = lat & ~lprev_m;
`else
    fire = lat;
`endif
    lprev_m = lat;
    ovs = 0; uns = 0;
    if (fire) begin
      case (tk)
        T_STORE: begin q[0] = din; if (cnt_m == 0) cnt_m = 1; end
        T_PUSH, T_DUP: begin
          tmp = (tk == T_PUSH) ? din : q[0];
          q.push_front(tmp); void'(q.pop_back());
          if (cnt_m == DEPTH) ovs = 1; else cnt_m++;
        end
        T_POP2: begin
          void'(q.pop_front()); void'(q.pop_front());
          q.push_front(din); q.push_back('0);
          if (cnt_m < 2) begin uns = 1; cnt_m = 1; end else cnt_m--;
        end
        T_SWAP: begin tmp = q[adr]; q[adr] = q[0]; q[0] = tmp; end
        T_POP: begin
          void'(q.pop_front()); q.push_back('0);
          if (cnt_m == 0) uns = 1; else cnt_m--;
        end
        T_ROT: if (adr != 0) begin
          tmp = q[adr]; q.delete(adr); q.push_front(tmp);
        end
        default: ;
      endcase
    end
    ov_m = ovs | (ov_m & ~clr);
    un_m = uns | (un_m & ~clr);
  endtask

  task automatic compare_all();
    check("out0",  32'(Out0), 32'(q[0]));
    check("out1",  32'(Out1), 32'(q[1]));
    check("outa",  32'(OutA), 32'(q[Address]));
    check("count", 32'(Count), 32'(cnt_m));
    check("full",  32'(Full), 32'(cnt_m == DEPTH));
    check("empty", 32'(Empty), 32'(cnt_m == 0));
    check("ovf",   32'(Overflow), 32'(ov_m));
    check("unf",   32'(Underflow), 32'(un_m));
  endtask

  // One clock: drive inputs, advance model on the edge, compare after it.
  task automatic step(input logic rst, input logic lat, input logic [2:0] tk,
                      input logic [WIDTH-1:0] din, input int adr, input logic clr);
    Reset = rst; Latch = lat; Task = tk; Input = din;
    Address = AW'(adr); ClearErr = clr;
    @(posedge Clk);
    model_step(rst, lat, tk, din, adr, clr);
    #1;
    compare_all();
  endtask

  // Issue one operation, with a Latch-low idle cycle so either strobe mode fires.
  task automatic op(input logic [2:0] tk, input logic [WIDTH-1:0] din, input int adr,
                    input logic clr);
    step(0, 0, T_NOP, '0, adr, 0);
    step(0, 1, tk, din, adr, clr);
  endtask

  initial begin
    model_reset();
    step(1, 0, T_NOP, '0, 0, 0);
    check("rst_empty", 32'(Empty), 32'd1);
    check("rst_count", 32'(Count), 32'd0);

    // Three pushes
    op(T_PUSH, 8'h11, 2, 0);
    op(T_PUSH, 8'h22, 2, 0);
    op(T_PUSH, 8'h33, 2, 0);
    check("p3_out0", 32'(Out0), 32'h33);
    check("p3_outa", 32'(OutA), 32'h11);

    // POP2 then ROT
    op(T_POP2, 8'h55, 1, 0);
    check("pop2_out1", 32'(Out1), 32'h11);
    check("pop2_cnt", 32'(Count), 32'd2);
    op(T_ROT, 8'h00, 1, 0);
    check("rot_out0", 32'(Out0), 32'h11);
    check("rot_out1", 32'(Out1), 32'h55);

    // SWAP on {A,B,C}
    step(1, 0, T_NOP, '0, 0, 0);
    op(T_PUSH, 8'h0C, 0, 0);
    op(T_PUSH, 8'h0B, 0, 0);
    op(T_PUSH, 8'h0A, 2, 0);
    op(T_SWAP, 8'h00, 2, 0);
    check("swap_out0", 32'(Out0), 32'h0C);
    check("swap_outa", 32'(OutA), 32'h0A);

    // Overflow: nine pushes
    step(1, 0, T_NOP, '0, 0, 0);
    for (int k = 1; k <= 9; k++) op(T_PUSH, 8'(k), 7, 0);
    check("ovf_full", 32'(Full), 32'd1);
    check("ovf_flag", 32'(Overflow), 32'd1);
    check("ovf_s7", 32'(OutA), 32'd2);
    op(T_POP, 8'h00, 7, 0);
    check("pop_cnt", 32'(Count), 32'd7);
    check("pop_s7", 32'(OutA), 32'd0);

    // Underflow and clear
    step(1, 0, T_NOP, '0, 0, 0);
    op(T_POP, 8'h00, 0, 0);
    check("unf_set", 32'(Underflow), 32'd1);
    op(T_POP, 8'h00, 0, 1);
    check("unf_setwins", 32'(Underflow), 32'd1);
    step(0, 0, T_NOP, '0, 0, 1);
    check("unf_clr", 32'(Underflow), 32'd0);

    // Latch held high for four cycles
    step(1, 0, T_NOP, '0, 0, 0);
    step(0, 0, T_NOP, '0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, T_PUSH, 8'(8'hA0 + k), 0, 0);
`ifdef CPU_STACK_LATCH_EDGE_EN
    check("held_cnt", 32'(Count), 32'd1);
`else
    check("held_cnt", 32'(Count), 32'd4);
`endif

    // Reset coinciding with a push
    step(0, 0, T_NOP, '0, 0, 0);
    step(1, 1, T_PUSH, 8'h77, 0, 0);
    check("rstpush_out0", 32'(Out0), 32'd0);
    check("rstpush_cnt", 32'(Count), 32'd0);

    // Random operations
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(63) == 0), ($urandom_range(3) != 0),
           3'($urandom_range(7)), 8'($urandom), $urandom_range(DEPTH - 1),
           ($urandom_range(7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
